// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between four requesters and the
// round-robin arbiter that drives a 2-to-4 decoder select path.
//
// Handshake: req[i] is a level request held high for as long as requester i
// wants the resource. A grant is valid while grant_en=1, and grant_addr/grant
// name the owner. The owner ends its tenure by pulsing done (sampled only while
// granted) or by dropping its req bit. Every grant is followed by at least one
// cycle with grant_en=0. timeout marks a grant that was reclaimed forcibly.
// arb_state publishes the arbiter FSM state (0 idle, 1 grant, 2 release).
interface rr_grant_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic       grant_en;
    logic [1:0] grant_addr;
    logic [3:0] grant;
    logic       timeout;
    logic [1:0] arb_state;

    modport master (
        input  req,
        input  done,
        output grant_en,
        output grant_addr,
        output grant,
        output timeout,
        output arb_state
    );

    modport slave (
        output req,
        output done,
        input  grant_en,
        input  grant_addr,
        input  grant,
        input  timeout,
        input  arb_state
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: four-requester round-robin arbiter for one shared slot.
// All outputs are registered; there is no combinational path from req/done to
// any output. The outgoing owner is always lowest priority next time round.
// Optional hold timeout is compiled in with the macro RR_ARB_TIMEOUT_EN; with
// it, a grant lasts at most HOLD_MAX cycles and timeout pulses on reclaim.
module rr_grant_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rr_grant_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > (2 ** CW) - 1) begin : g_bad_hold_max
        $error("rr_grant_arbiter: HOLD_MAX must lie in 2..2^CW-1");
    end

    state_t     state;
    state_t     state_n;
    logic [1:0] last;
    logic [1:0] last_n;
    logic       grant_en_q;
    logic       grant_en_n;
    logic [1:0] grant_addr_q;
    logic [1:0] grant_addr_n;
    logic [3:0] grant_q;
    logic [1:0] winner;
    logic [1:0] probe;
    logic       rel_normal;
    logic       to_cond;

`ifdef RR_ARB_TIMEOUT_EN
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_n;
    logic          timeout_q;
    logic          timeout_n;

    // Forced release only when the owner is neither finishing nor leaving.
    assign to_cond = (state == GRANT) && !rel_normal &&
                     (hold_cnt == CW'(HOLD_MAX - 1));
`else
    assign to_cond = 1'b0;
`endif

    assign rel_normal = bus.done || !bus.req[grant_addr_q];

    // Round-robin search: last+1, last+2, last+3, last; first set bit wins.
    always_comb begin
        winner = last;
        probe  = last;
        for (int k = 4; k >= 1; k--) begin
            probe = last + 2'(k);
            if (bus.req[probe]) begin
                winner = probe;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) state_n = GRANT;
            end
            GRANT: begin
                if (rel_normal || to_cond) state_n = RELEASE;
            end
            RELEASE: begin
                state_n = (bus.req != 4'b0000) ? GRANT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and pointer.
    always_comb begin
        grant_en_n   = grant_en_q;
        grant_addr_n = grant_addr_q;
        last_n       = last;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_n   = hold_cnt;
        timeout_n    = 1'b0;
`endif
        case (state)
            IDLE, RELEASE: begin
                if (bus.req != 4'b0000) begin
                    grant_en_n   = 1'b1;
                    grant_addr_n = winner;
                    last_n       = winner;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_n   = '0;
`endif
                end else begin
                    grant_en_n = 1'b0;
                end
            end
            GRANT: begin
                if (rel_normal || to_cond) begin
                    grant_en_n = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
                    timeout_n  = to_cond;
`endif
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (hold_cnt != {CW{1'b1}}) begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end
`endif
                end
            end
            default: grant_en_n = 1'b0;
        endcase
    end

    // Output and pointer registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_en_q   <= 1'b0;
            grant_addr_q <= 2'd0;
            grant_q      <= 4'b0000;
            last         <= 2'd3;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            grant_en_q   <= grant_en_n;
            grant_addr_q <= grant_addr_n;
            grant_q      <= grant_en_n ? (4'b0001 << grant_addr_n) : 4'b0000;
            last         <= last_n;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt     <= hold_cnt_n;
            timeout_q    <= timeout_n;
`endif
        end
    end

    assign bus.grant_en   = grant_en_q;
    assign bus.grant_addr = grant_addr_q;
    assign bus.grant      = grant_q;
    assign bus.arb_state  = state;
`ifdef RR_ARB_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the arbiter rules.
module tb_rr_grant_arbiter;

    localparam int HOLD = 4;
    localparam int CW   = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rr_grant_arbiter_if bus ();

    rr_grant_arbiter #(
        .HOLD_MAX (HOLD),
        .CW       (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 granted, 2 just released (matches arb_state debug).
    int m_phase;
    int m_addr;
    int m_last;
    int m_hold;
    bit m_to;

    task automatic model_reset();
        m_phase = 0;
        m_addr  = 0;
        m_last  = 3;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        int pick;
        m_to = 1'b0;
        if (m_phase == 1) begin
            if (d || !r[m_addr]) begin
                m_phase = 2;
            end else if (TO_EN && (m_hold + 1 >= HOLD)) begin
                m_phase = 2;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (r != 4'b0000) begin
            pick = -1;
            for (int k = 1; k <= 4; k++) begin
                if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
            end
            m_addr  = pick;
            m_last  = pick;
            m_hold  = 0;
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_grant;
        logic       exp_en;
        exp_en    = (m_phase == 1);
        exp_grant = exp_en ? (4'b0001 << m_addr) : 4'b0000;
        chk({tag, ".en"},    {3'b000, bus.grant_en},   {3'b000, exp_en});
        chk({tag, ".addr"},  {2'b00, bus.grant_addr},  4'(m_addr));
        chk({tag, ".grant"}, bus.grant,                exp_grant);
        chk({tag, ".tmo"},   {3'b000, bus.timeout},    {3'b000, m_to});
        chk({tag, ".state"}, {2'b00, bus.arb_state},   4'(m_phase));
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic [3:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rr_seq [4];
        logic [3:0] r;
        logic       d;

        rr_seq[0] = 4'b0010;
        rr_seq[1] = 4'b0100;
        rr_seq[2] = 4'b1000;
        rr_seq[3] = 4'b0001;

        reset_n  = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;

        // 1: all requesting, done pulsed each grant -> rotation 0,1,2,3,0.
        step("t1.first", 4'b1111, 1'b0);
        chk("t1.first_grant", bus.grant, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step("t1.gap", 4'b1111, 1'b1);
            chk("t1.gap_grant", bus.grant, 4'b0000);
            step("t1.next", 4'b1111, 1'b0);
            chk("t1.rotate", bus.grant, rr_seq[i]);
        end
        step("t1.rel", 4'b0000, 1'b1);
        step("t1.idle", 4'b0000, 1'b0);

        // 2: single requester, then drop request without done.
        step("t2.grant", 4'b0100, 1'b0);
        chk("t2.grant_val", bus.grant, 4'b0100);
        step("t2.drop", 4'b0000, 1'b0);
        chk("t2.drop_val", bus.grant, 4'b0000);
        step("t2.idle", 4'b0000, 1'b0);
        chk("t2.idle_state", {2'b00, bus.arb_state}, 4'd0);

        // 3: owner 1 releases with 1011 pending -> 3 wins, 2 skipped.
        step("t3.own1", 4'b0010, 1'b0);
        chk("t3.own1_val", bus.grant, 4'b0010);
        step("t3.hold", 4'b1011, 1'b0);
        step("t3.rel", 4'b1011, 1'b1);
        step("t3.next", 4'b1011, 1'b0);
        chk("t3.next_val", bus.grant, 4'b1000);
        step("t3.rel2", 4'b0000, 1'b1);
        step("t3.idle", 4'b0000, 1'b0);

        // 4: stuck owner with req 0011 and no done.
        for (int i = 0; i < 6; i++) begin
            step("t4", 4'b0011, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
            if (i < 4) chk("t4.held", bus.grant, 4'b0001);
            if (i == 4) chk("t4.pulse", {3'b000, bus.timeout}, 4'd1);
            if (i == 5) chk("t4.after", bus.grant, 4'b0010);
`else
            chk("t4.persist", bus.grant, 4'b0001);
`endif
        end
        step("t4.rel", 4'b0000, 1'b1);
        step("t4.idle", 4'b0000, 1'b0);

        // 6: done coincides with the timeout cycle -> normal release.
        for (int i = 0; i < 4; i++) step("t6.hold", 4'b0001, 1'b0);
        step("t6.done", 4'b0001, 1'b1);
        chk("t6.no_tmo", {3'b000, bus.timeout}, 4'd0);
        chk("t6.released", {3'b000, bus.grant_en}, 4'd0);
        step("t6.idle", 4'b0000, 1'b0);

        // 5: asynchronous reset mid-grant.
        step("t5.own1", 4'b0010, 1'b0);
        step("t5.hold", 4'b0010, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5.async_en",    {3'b000, bus.grant_en}, 4'd0);
        chk("t5.async_grant", bus.grant,              4'b0000);
        chk("t5.async_tmo",   {3'b000, bus.timeout},  4'd0);
        model_reset();
        @(negedge clk);
        check_all("t5.in_reset");
        reset_n = 1'b1;
        step("t5.first", 4'b1111, 1'b0);
        chk("t5.first_val", bus.grant, 4'b0001);

        // Randomized traffic; requests tend to persist so grants get long.
        r = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 4) == 0);
            step("rand", r, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
